ota_sd_decimator: RTL and testbench

Digital back end for the on-chip digital OTA when it is configured as a first-order sigma-delta loop (OTA integrator plus comparator). The block does three things:
- samples the comparator bit arriving on a dedicated input;
- returns that bit as the 1-bit feedback DAC drive;
- counts ones over a programmable window and presents each window result to the tile's output logic through a valid/ready handshake.

It sits between the analog macro pins and the tile's digital pad logic.

---
 rtl/ota_sd_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/ota_sd_decimator.sv | 153 +++++++++++++++
 tb/tb_ota_sd_decimator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ota_sd_pkg.sv
// ota_sd_pkg
// Shared types and constants for the sigma-delta decimator back end.
//   state_e    : FSM states (IDLE, SETTLE, ACQ)
//   *_DEF      : default oversampling ratio (log2) and settle length
//   calc_rw    : result width needed to hold a full-window count
//   calc_cw    : sample counter width covering both SETTLE and ACQ phases
package ota_sd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACQ    = 2'd2
    } state_e;

    localparam int OSR_LOG2_DEF   = 8;
    localparam int SETTLE_CYC_DEF = 16;

    // A window of 2^osr_log2 ones needs one extra bit above osr_log2.
    function automatic int calc_rw(input int osr_log2);
        return osr_log2 + 1;
    endfunction

    function automatic int calc_cw(input int osr_log2, input int settle_cyc);
        int sw;
        sw = $clog2(settle_cyc + 1);
        return (osr_log2 > sw) ? osr_log2 : sw;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Generic single-bit two-flop synchronizer for bringing an asynchronous
// level into the clk domain.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles after d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ota_sd_decimator.sv
// ota_sd_decimator
// Digital back end for the OTA configured as a first-order sigma-delta loop.
// Synchronizes the comparator bit, drives it back as the 1-bit feedback DAC,
// and counts ones over windows of 2^OSR_LOG2 samples after a settle period.
// Ports:
//   clk, rst_n    : tile clock, asynchronous active-low reset
//   ena           : tile enable; low aborts any conversion (partial discarded)
//   comp_in       : raw comparator output (asynchronous)
//   fb_out        : feedback DAC drive (registered synchronized comparator bit)
//   start         : one-cycle pulse, begins a conversion from IDLE
//   cont          : continuous mode, sampled at each window end
//   result        : ones count of the last window, 0..2^OSR_LOG2
//   result_valid  : result available; cleared by result_ready handshake
//   result_ready  : consumer accepts result
//   overrun       : sticky, set when an unread result is overwritten
//   clr_ovr       : synchronous clear of overrun (a same-cycle set wins)
module ota_sd_decimator
    import ota_sd_pkg::*;
#(
    parameter int OSR_LOG2   = OSR_LOG2_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int RW         = calc_rw(OSR_LOG2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          comp_in,
    output logic          fb_out,
    input  logic          start,
    input  logic          cont,
    output logic [RW-1:0] result,
    output logic          result_valid,
    input  logic          result_ready,
    output logic          overrun,
    input  logic          clr_ovr
);

    localparam int            CW          = calc_cw(OSR_LOG2, SETTLE_CYC);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] ACQ_LAST    = CW'((1 << OSR_LOG2) - 1);

    logic          comp_s;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [RW-1:0] result_q, result_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          fb_q, fb_d;
    logic [RW-1:0] acc_sum;
    logic          load;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (comp_in),
        .q     (comp_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        fb_d     = comp_s;
        load     = 1'b0;
        // The final sample of a window is folded in on the load cycle itself,
        // so the loaded value can reach the full 2^OSR_LOG2.
        acc_sum  = acc_q + RW'(comp_s);

        if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end

        if (!ena) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ACQ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ACQ: begin
                    if (cnt_q == ACQ_LAST) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                        // Continuous mode re-enters ACQ directly: no gap samples.
                        state_d = cont ? ACQ : IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        acc_d = acc_sum;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A load always leaves valid high; a simultaneous ready consumes the
        // old value cleanly, otherwise the old value is lost and flagged.
        if (load) begin
            result_d = acc_sum;
            valid_d  = 1'b1;
            if (valid_q && !result_ready) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            fb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            fb_q     <= fb_d;
        end
    end

    assign fb_out       = fb_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_ota_sd_decimator.sv
// tb_ota_sd_decimator
// Directed bench for ota_sd_decimator with default parameters.
// Cycle numbers below count active edges after the cycle in which start
// is driven (that cycle is cycle 0); inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_ota_sd_decimator;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       comp_in;
    logic       fb_out;
    logic       start;
    logic       cont;
    logic [8:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       overrun;
    logic       clr_ovr;

    int n_cmp;
    int n_bad;
    int cyc;
    bit tgl;
    bit seen_v;

    ota_sd_decimator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .comp_in      (comp_in),
        .fb_out       (fb_out),
        .start        (start),
        .cont         (cont),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun),
        .clr_ovr      (clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tgl) comp_in = ~comp_in;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; tgl = 0; seen_v = 0;
        rst_n = 0; ena = 1; start = 0; comp_in = 0; cont = 0;
        result_ready = 0; clr_ovr = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_result", result, 0);
        check_eq("rst_valid", result_valid, 0);
        check_eq("rst_ovr", overrun, 0);
        check_eq("rst_fb", fb_out, 0);
        rst_n = 1;
        tick();

        // All ones: full-scale 256, fb latency 3
        comp_in = 1; result_ready = 1;
        pulse_start();
        run_to(2);   check_eq("fb_lat2", fb_out, 0);
        run_to(3);   check_eq("fb_lat3", fb_out, 1);
        run_to(272); check_eq("ones_valid_early", result_valid, 0);
        run_to(273); check_eq("ones_valid", result_valid, 1);
                     check_eq("ones_result", result, 256);
        run_to(274); check_eq("ones_consumed", result_valid, 0);

        // All zeros
        comp_in = 0;
        pulse_start();
        run_to(273); check_eq("zeros_valid", result_valid, 1);
                     check_eq("zeros_result", result, 0);
        run_to(274);

        // Toggling input, plus an extra start during SETTLE that must be ignored
        tgl = 1;
        pulse_start();
        run_to(5);
        start = 1; tick(); start = 0;
        run_to(272); check_eq("tgl_valid_early", result_valid, 0);
        run_to(273); check_eq("tgl_valid", result_valid, 1);
                     check_eq("tgl_result", result, 128);
        tgl = 0;
        run_to(274);

        // Continuous mode overrun, clr_ovr, and set-wins-over-clear
        comp_in = 1; cont = 1; result_ready = 0;
        pulse_start();
        run_to(273); check_eq("cont_w1_valid", result_valid, 1);
                     check_eq("cont_w1_ovr", overrun, 0);
        run_to(528); check_eq("cont_pre_ovr", overrun, 0);
        run_to(529); check_eq("cont_ovr_set", overrun, 1);
                     check_eq("cont_w2_valid", result_valid, 1);
                     check_eq("cont_w2_result", result, 256);
        clr_ovr = 1; tick(); clr_ovr = 0;
        check_eq("clr_ovr", overrun, 0);
        cont = 0;
        run_to(784);
        clr_ovr = 1; tick(); clr_ovr = 0;
        check_eq("ovr_set_wins", overrun, 1);
        check_eq("w3_valid", result_valid, 1);
        result_ready = 1; tick(); result_ready = 0;
        check_eq("w3_consumed", result_valid, 0);
        clr_ovr = 1; tick(); clr_ovr = 0;

        // Ready on the load edge of window 2: no overrun, valid continuous
        comp_in = 1; cont = 1; result_ready = 0;
        pulse_start();
        run_to(271); comp_in = 0;
        run_to(273); check_eq("rdy_w1_result", result, 256);
        run_to(528); check_eq("rdy_pre_valid", result_valid, 1);
                     check_eq("rdy_pre_result", result, 256);
        result_ready = 1; tick(); result_ready = 0;
        check_eq("rdy_load_valid", result_valid, 1);
        check_eq("rdy_load_result", result, 0);
        check_eq("rdy_load_ovr", overrun, 0);
        cont = 0;
        run_to(786);

        // Reset mid-ACQ, then a clean window after release
        comp_in = 1; result_ready = 0;
        pulse_start();
        run_to(99);  check_eq("prerst_valid", result_valid, 1);
                     check_eq("prerst_ovr", overrun, 1);
        run_to(100);
        rst_n = 0; tick();
        check_eq("midrst_result", result, 0);
        check_eq("midrst_valid", result_valid, 0);
        check_eq("midrst_ovr", overrun, 0);
        check_eq("midrst_fb", fb_out, 0);
        rst_n = 1; tick(); tick();
        check_eq("postrst_idle_valid", result_valid, 0);
        result_ready = 1;
        pulse_start();
        run_to(272); check_eq("postrst_valid_early", result_valid, 0);
        run_to(273); check_eq("postrst_valid", result_valid, 1);
                     check_eq("postrst_result", result, 256);
        run_to(274); check_eq("postrst_consumed", result_valid, 0);

        // ena low mid-conversion aborts, partial count discarded
        pulse_start();
        run_to(5);
        start = 1; tick(); start = 0;
        run_to(50);
        ena = 0; tick(); ena = 1;
        seen_v = 0;
        while (cyc < 300) begin
            tick();
            if (result_valid) seen_v = 1;
        end
        check_eq("ena_no_valid", seen_v, 0);
        check_eq("ena_result_kept", result, 256);
        pulse_start();
        run_to(272); check_eq("ena_restart_early", result_valid, 0);
        run_to(273); check_eq("ena_restart_result", result, 256);
                     check_eq("ena_restart_valid", result_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
